// File: rtl/ama_riscv_fetch.sv
// ---------------------------------------------------------------------------
// ama_riscv_fetch
//   Instruction fetch stage plus the IF/ID pipeline register that feeds the
//   decoder. Holds the PC, picks the next PC from the decoder's pc_sel/pc_we,
//   drives a synchronous-read IMEM and registers {inst, pc} into ID.
//   Around reset it injects NOP bubbles so the decoder never sees stale
//   IMEM data.
//
// Ports
//   clk          in   1        clock, all state updates on posedge
//   rst          in   1        synchronous, active-high reset
//   pc_sel       in   2        next-PC select (START_ADDR / INC4 / ALU / hold)
//   pc_we        in   1        PC write enable (already gated with stall)
//   alu_out      in   32       branch/jump target from the EX ALU
//   stall_if     in   1        hold PC and IF/ID register
//   clear_if     in   1        flush IF/ID register to a bubble
//   imem_addr    out  IMEM_AW  IMEM word address (combinational)
//   imem_en      out  1        IMEM read enable, tied high
//   imem_rdata   in   32       IMEM data, valid one cycle after imem_addr
//   pc_if        out  32       current PC (address of imem_rdata this cycle)
//   inst_id      out  32       registered instruction to the decoder
//   pc_id        out  32       registered PC of inst_id
//   inst_id_vld  out  1        inst_id is a real fetched instruction
// ---------------------------------------------------------------------------
module ama_riscv_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned IMEM_AW      = 14,
  parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         pc_sel,
  input  logic               pc_we,
  input  logic [31:0]        alu_out,
  input  logic               stall_if,
  input  logic               clear_if,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_en,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc_if,
  output logic [31:0]        inst_id,
  output logic [31:0]        pc_id,
  output logic               inst_id_vld
);

  // Next-PC select encodings shared with the decoder; 2'd3 is reserved (hold).
  localparam logic [1:0] PC_SEL_START_ADDR = 2'd0;
  localparam logic [1:0] PC_SEL_INC4       = 2'd1;
  localparam logic [1:0] PC_SEL_ALU        = 2'd2;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_nxt;
  logic        pc_adv;

  logic        rst_bub_q;
  logic        rst_bub_d;

  logic [31:0] inst_f;
  logic        vld_f;

  logic [31:0] inst_id_q;
  logic [31:0] inst_id_d;
  logic [31:0] pc_id_q;
  logic [31:0] pc_id_d;
  logic        vld_id_q;
  logic        vld_id_d;

  // Next-PC mux; ALU targets are forced word aligned rather than trapping.
  always_comb begin
    pc_nxt = pc_q;
    case (pc_sel)
      PC_SEL_START_ADDR: pc_nxt = RESET_VECTOR;
      PC_SEL_INC4:       pc_nxt = pc_q + 32'd4;
      PC_SEL_ALU:        pc_nxt = alu_out & 32'hFFFF_FFFC;
      default:           pc_nxt = pc_q;
    endcase
  end

  // PC advance qualifier and PC next-state.
  always_comb begin
    pc_adv = pc_we & ~stall_if;
    if (pc_adv) begin
      pc_d = pc_nxt;
    end else begin
      pc_d = pc_q;
    end
  end

  // IMEM address always points at the PC that will be current next cycle,
  // so the synchronous read data lines up with pc_if.
  always_comb begin
    if (rst) begin
      imem_addr = RESET_VECTOR[IMEM_AW+1:2];
    end else if (pc_adv) begin
      imem_addr = pc_nxt[IMEM_AW+1:2];
    end else begin
      imem_addr = pc_q[IMEM_AW+1:2];
    end
  end

  assign imem_en = 1'b1;

  // Reset bubble: the cycle right after reset still carries stale IMEM data.
  always_comb begin
    rst_bub_d = 1'b0;
    if (rst_bub_q) begin
      inst_f = NOP_INST;
      vld_f  = 1'b0;
    end else begin
      inst_f = imem_rdata;
      vld_f  = 1'b1;
    end
  end

  // IF/ID next-state: flush beats stall, stall beats load.
  always_comb begin
    inst_id_d = inst_id_q;
    pc_id_d   = pc_id_q;
    vld_id_d  = vld_id_q;
    if (clear_if) begin
      inst_id_d = NOP_INST;
      pc_id_d   = pc_q;
      vld_id_d  = 1'b0;
    end else if (stall_if) begin
      inst_id_d = inst_id_q;
      pc_id_d   = pc_id_q;
      vld_id_d  = vld_id_q;
    end else begin
      inst_id_d = inst_f;
      pc_id_d   = pc_q;
      vld_id_d  = vld_f;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_VECTOR;
      rst_bub_q <= 1'b1;
      inst_id_q <= NOP_INST;
      pc_id_q   <= RESET_VECTOR;
      vld_id_q  <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      rst_bub_q <= rst_bub_d;
      inst_id_q <= inst_id_d;
      pc_id_q   <= pc_id_d;
      vld_id_q  <= vld_id_d;
    end
  end

  assign pc_if       = pc_q;
  assign inst_id     = inst_id_q;
  assign pc_id       = pc_id_q;
  assign inst_id_vld = vld_id_q;

endmodule

// File: tb/tb_ama_riscv_fetch.sv
module tb_ama_riscv_fetch;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_INC4  = 2'd1;
  localparam logic [1:0] S_ALU   = 2'd2;
  localparam logic [1:0] S_RSVD  = 2'd3;

  logic        clk;
  logic        rst;
  logic [1:0]  pc_sel;
  logic        pc_we;
  logic [31:0] alu_out;
  logic        stall_if;
  logic        clear_if;
  logic [13:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic [31:0] pc_if;
  logic [31:0] inst_id;
  logic [31:0] pc_id;
  logic        inst_id_vld;

  int n_vec;
  int n_err;

  // Reference model state: what the pipeline holds, in architectural terms.
  logic [31:0] m_pc;
  logic        m_bub;
  logic [31:0] m_inst;
  logic [31:0] m_pcid;
  logic        m_vld;

  ama_riscv_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .pc_sel     (pc_sel),
    .pc_we      (pc_we),
    .alu_out    (alu_out),
    .stall_if   (stall_if),
    .clear_if   (clear_if),
    .imem_addr  (imem_addr),
    .imem_en    (imem_en),
    .imem_rdata (imem_rdata),
    .pc_if      (pc_if),
    .inst_id    (inst_id),
    .pc_id      (pc_id),
    .inst_id_vld(inst_id_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IMEM contents: word i holds the value i.
  always @(posedge clk) imem_rdata <= {18'd0, imem_addr};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {18'd0, a[15:2]};
  endfunction

  // PC this model expects after the coming edge.
  function automatic logic [31:0] next_pc(input logic [1:0] sel, input logic we,
                                          input logic [31:0] alu, input logic st,
                                          input logic r);
    logic [31:0] t;
    if (r) return RV;
    if (!we || st) return m_pc;
    case (sel)
      S_START: t = RV;
      S_INC4:  t = m_pc + 32'd4;
      S_ALU:   t = {alu[31:2], 2'b00};
      default: t = m_pc;
    endcase
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare against the model mid-cycle, advance model.
  task automatic step(input logic [1:0] sel, input logic we, input logic [31:0] alu,
                      input logic st, input logic cl, input logic r);
    logic [31:0] np;
    logic [31:0] f_inst;
    logic        f_vld;
    pc_sel = sel; pc_we = we; alu_out = alu; stall_if = st; clear_if = cl; rst = r;
    np = next_pc(sel, we, alu, st, r);
    @(negedge clk);
    chk("pc_if",     pc_if, m_pc);
    chk("inst_id",   inst_id, m_inst);
    chk("pc_id",     pc_id, m_pcid);
    chk("vld",       {31'd0, inst_id_vld}, {31'd0, m_vld});
    chk("imem_addr", {18'd0, imem_addr}, {18'd0, np[15:2]});
    chk("imem_en",   {31'd0, imem_en}, 32'd1);
    @(posedge clk);
    if (r) begin
      m_inst = NOP; m_pcid = RV; m_vld = 1'b0; m_bub = 1'b1;
    end else begin
      f_inst = m_bub ? NOP : mem_word(m_pc);
      f_vld  = !m_bub;
      if (cl) begin
        m_inst = NOP; m_pcid = m_pc; m_vld = 1'b0;
      end else if (!st) begin
        m_inst = f_inst; m_pcid = m_pc; m_vld = f_vld;
      end
      m_bub = 1'b0;
    end
    m_pc = np;
    #1;
  endtask

  // Reset release then START_ADDR then INC4, with literal expectations.
  task automatic boot_seq();
    step(S_START, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("t1_bubble_vld", {31'd0, inst_id_vld}, 32'd0);
    chk("t1_bubble_inst", inst_id, 32'h0000_0013);
    for (int i = 0; i < 3; i++) begin
      step(S_INC4, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      chk("t1_inst", inst_id, 32'(i));
      chk("t1_pcid", pc_id, 32'(4 * i));
      chk("t1_vld", {31'd0, inst_id_vld}, 32'd1);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; pc_sel = S_START; pc_we = 1'b1; alu_out = 32'd0;
    stall_if = 1'b0; clear_if = 1'b0;
    m_pc = RV; m_bub = 1'b1; m_inst = NOP; m_pcid = RV; m_vld = 1'b0;
    @(posedge clk); #1;

    // Reset state
    step(S_START, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("rst_pc_if", pc_if, 32'h0);
    chk("rst_inst", inst_id, 32'h13);
    chk("rst_vld", {31'd0, inst_id_vld}, 32'd0);

    // Test 1
    boot_seq();

    // Test 2: reach pc=0x10, stall two cycles, resume
    step(S_INC4, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("t2_pc", pc_if, 32'h10);
    for (int i = 0; i < 2; i++) begin
      step(S_INC4, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      chk("t2_pc_frozen", pc_if, 32'h10);
      chk("t2_pcid_frozen", pc_id, 32'hC);
      chk("t2_inst_frozen", inst_id, 32'h3);
      chk("t2_imem_addr", {18'd0, imem_addr}, 32'd4);
    end
    step(S_INC4, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("t2_resume_inst", inst_id, 32'h4);
    chk("t2_resume_pcid", pc_id, 32'h10);

    // Test 3: taken branch with flush
    step(S_ALU, 1'b1, 32'h0000_0043, 1'b0, 1'b1, 1'b0);
    chk("t3_pc", pc_if, 32'h40);
    chk("t3_inst", inst_id, 32'h13);
    chk("t3_vld", {31'd0, inst_id_vld}, 32'd0);
    step(S_INC4, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("t3_pcid", pc_id, 32'h40);
    chk("t3_tinst", inst_id, 32'h10);

    // Test 4: clear and stall together
    step(S_INC4, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    chk("t4_inst", inst_id, 32'h13);
    chk("t4_vld", {31'd0, inst_id_vld}, 32'd0);

    // Test 5: wrap and reserved select
    step(S_ALU, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    chk("t5_pc_top", pc_if, 32'hFFFF_FFFC);
    step(S_INC4, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("t5_wrap", pc_if, 32'h0);
    chk("t5_alias_inst", inst_id, 32'h3FFF);
    step(S_RSVD, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("t5_hold", pc_if, 32'h0);

    // Test 6: reset mid-stream
    step(S_INC4, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    step(S_INC4, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("t6_pc", pc_if, 32'h0);
    chk("t6_inst", inst_id, 32'h13);
    chk("t6_pcid", pc_id, 32'h0);
    chk("t6_vld", {31'd0, inst_id_vld}, 32'd0);
    boot_seq();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 8),
           $urandom,
           ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 9) < 1),
           ($urandom_range(0, 49) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
